// File: rtl/br_flow_arb_wrr.sv
// Weighted round-robin arbiter.
// Holds the current owner and its burst count. The owner keeps the grant
// for up to eff_w consecutive transfers, then the grant rotates to the next
// valid flow. Decisions are only committed when the consumer can accept.
module br_flow_arb_wrr #(
    parameter  int NumFlows    = 2,
    parameter  int WeightWidth = 4,
    localparam int IdxWidth    = $clog2(NumFlows)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                can_accept,
    input  logic [NumFlows-1:0]                 push_valid,
    input  logic [NumFlows-1:0][WeightWidth-1:0] cfg_weight,
    output logic [NumFlows-1:0]                 grant,
    output logic [IdxWidth-1:0]                 grant_idx
);

    typedef logic [IdxWidth-1:0] flow_idx_t;

    flow_idx_t              owner;
    logic [WeightWidth-1:0] burst_cnt;
    logic [WeightWidth-1:0] eff_w;
    logic                   any_valid;
    logic                   stay;
    logic                   found;
    flow_idx_t              rot_idx;
    flow_idx_t              cand_idx;
    int                     cand;

    if (NumFlows < 2) begin : g_bad_num_flows
        $error("br_flow_arb_wrr: NumFlows must be >= 2");
    end
    if (WeightWidth < 1) begin : g_bad_weight_width
        $error("br_flow_arb_wrr: WeightWidth must be >= 1");
    end

    // Stay-or-rotate grant decision from the owner's weight and the valid vector.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        eff_w     = (cfg_weight[owner] == '0) ? WeightWidth'(1) : cfg_weight[owner];
        any_valid = |push_valid;
        // burst_cnt == 0 only after reset: no flow holds a burst yet, so the
        // first decision is a rotate starting at owner+1 (flow 0).
        stay      = push_valid[owner] && (burst_cnt != '0) && (burst_cnt < eff_w);
        found     = 1'b0;
        rot_idx   = owner;
        cand      = 0;
        cand_idx  = '0;
        // Scan owner+1 .. owner+NumFlows (wrapping), so the owner itself is last.
        for (int k = 1; k <= NumFlows; k++) begin
            cand = int'(owner) + k;
            if (cand >= NumFlows) begin
                cand = cand - NumFlows;
            end
            cand_idx = flow_idx_t'(cand);
            if (!found && push_valid[cand_idx]) begin
                found   = 1'b1;
                rot_idx = cand_idx;
            end
        end
        grant_idx = stay ? owner : rot_idx;
        grant     = (can_accept && any_valid) ? (NumFlows'(1) << grant_idx) : '0;
    end

    // Commit owner and burst count only when a grant actually transfers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            owner     <= flow_idx_t'(NumFlows - 1);
            burst_cnt <= '0;
        end else if (can_accept && any_valid) begin
            if (stay) begin
                burst_cnt <= burst_cnt + WeightWidth'(1);
            end else begin
                owner     <= rot_idx;
                burst_cnt <= WeightWidth'(1);
            end
        end
    end

    cov_weight_exhausted: cover property (@(posedge clk) disable iff (!rst)
        can_accept && push_valid[owner] && (burst_cnt != '0) && !stay);

endmodule

// File: rtl/br_flow_mux_wrr_reg.sv
// Flow-controlled WRR multiplexer with a registered 1-entry pop stage.
// The arbiter picks a flow, the selected payload is loaded into the output
// register whenever it is empty or being drained, giving 1 transfer/cycle.
module br_flow_mux_wrr_reg #(
    parameter  int NumFlows    = 2,
    parameter  int DataWidth   = 1,
    parameter  int WeightWidth = 4,
    localparam int IdxWidth    = $clog2(NumFlows)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumFlows-1:0][WeightWidth-1:0] cfg_weight,
    output logic [NumFlows-1:0]                  push_ready,
    input  logic [NumFlows-1:0]                  push_valid,
    input  logic [NumFlows-1:0][DataWidth-1:0]   push_data,
    input  logic                                 pop_ready,
    output logic                                 pop_valid,
    output logic [DataWidth-1:0]                 pop_data,
    output logic [IdxWidth-1:0]                  pop_flow_id
);

    logic                can_accept;
    logic [NumFlows-1:0] grant;
    logic [IdxWidth-1:0] grant_idx;
    logic                grant_any;

    if (NumFlows < 2) begin : g_bad_num_flows
        $error("br_flow_mux_wrr_reg: NumFlows must be >= 2");
    end
    if (DataWidth < 1) begin : g_bad_data_width
        $error("br_flow_mux_wrr_reg: DataWidth must be >= 1");
    end
    if (WeightWidth < 1) begin : g_bad_weight_width
        $error("br_flow_mux_wrr_reg: WeightWidth must be >= 1");
    end

    // Nothing is accepted while reset is asserted: the entry would be discarded anyway.
    assign can_accept = rst && (!pop_valid || pop_ready);
    assign grant_any  = |grant;
    assign push_ready = grant;

    br_flow_arb_wrr #(
        .NumFlows    (NumFlows),
        .WeightWidth (WeightWidth)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .can_accept (can_accept),
        .push_valid (push_valid),
        .cfg_weight (cfg_weight),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Output register: load on a grant, drain when the consumer takes the entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pop_valid   <= 1'b0;
            pop_data    <= '0;
            pop_flow_id <= '0;
        end else if (can_accept) begin
            pop_valid <= grant_any;
            if (grant_any) begin
                pop_data    <= push_data[grant_idx];
                pop_flow_id <= grant_idx;
            end
        end
    end

    ast_push_ready_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(push_ready));

    ast_pop_stable: assert property (@(posedge clk) disable iff (!rst)
        pop_valid && !pop_ready |=> pop_valid && $stable(pop_data) && $stable(pop_flow_id));

    for (genvar i = 0; i < NumFlows; i++) begin : g_cov_flow
        cov_flow_granted: cover property (@(posedge clk) disable iff (!rst)
            push_ready[i] && push_valid[i]);
    end

endmodule

// File: tb/tb_br_flow_mux_wrr_reg.sv
// Directed bench for br_flow_mux_wrr_reg with three flows, 8-bit payload.
// Each flow drives a constant payload 8'hA0 + flow index, so pop_data must
// always match the flow reported on pop_flow_id.
module tb_br_flow_mux_wrr_reg;

    localparam int NumFlows    = 3;
    localparam int DataWidth   = 8;
    localparam int WeightWidth = 4;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic [NumFlows-1:0][WeightWidth-1:0] cfg_weight;
    logic [NumFlows-1:0]                  push_ready;
    logic [NumFlows-1:0]                  push_valid;
    logic [NumFlows-1:0][DataWidth-1:0]   push_data;
    logic                                 pop_ready;
    logic                                 pop_valid;
    logic [DataWidth-1:0]                 pop_data;
    logic [1:0]                           pop_flow_id;

    int n_checks = 0;
    int n_errors = 0;

    int seq2[8] = '{1, 1, 2, 2, 2, 0, 1, 1};
    int seq3[6] = '{0, 1, 1, 0, 1, 1};
    int seq4[5] = '{0, 1, 1, 1, 0};
    int seq6[6] = '{1, 1, 1, 1, 0, 1};

    br_flow_mux_wrr_reg #(
        .NumFlows    (NumFlows),
        .DataWidth   (DataWidth),
        .WeightWidth (WeightWidth)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_weight  (cfg_weight),
        .push_ready  (push_ready),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .pop_ready   (pop_ready),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .pop_flow_id (pop_flow_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge before looking at outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pop(input string tag, input int id);
        check({tag, "_valid"}, 32'(pop_valid), 32'd1);
        check({tag, "_id"}, 32'(pop_flow_id), 32'(id));
        check({tag, "_data"}, 32'(pop_data), 32'hA0 + 32'(id));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_pop_flow_id", 32'(pop_flow_id), 32'd0);
        check("rst_pop_data", 32'(pop_data), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NumFlows; i++) begin
            push_data[i] = DataWidth'(8'hA0 + i);
        end
        rst        = 1'b0;
        pop_ready  = 1'b1;
        push_valid = 3'b111;
        cfg_weight = {4'd3, 4'd2, 4'd1};

        // Reset held for 3 cycles with all flows valid.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t1_rst%0d_pop_valid", i), 32'(pop_valid), 32'd0);
            check($sformatf("t1_rst%0d_push_ready", i), 32'(push_ready), 32'd0);
        end
        rst = 1'b1;
        #1;
        check("t1_first_grant", 32'(push_ready), 32'b001);
        tick();
        expect_pop("t1_first_pop", 0);

        // Weights {1,2,3}, all valid, continuous drain.
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_pop($sformatf("t2_%0d", i), seq2[i]);
        end

        // Weights {0,2}: weight 0 behaves as 1. Reset discards the held entry.
        cfg_weight = {4'd0, 4'd2, 4'd0};
        push_valid = 3'b011;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_pop($sformatf("t3_%0d", i), seq3[i]);
        end

        // Weights {3,3}, stall for 3 cycles after the second pop.
        cfg_weight = {4'd0, 4'd3, 4'd3};
        push_valid = 3'b011;
        do_reset();
        tick();
        expect_pop("t4_pop0", 0);
        tick();
        expect_pop("t4_pop1", 0);
        pop_ready = 1'b0;
        #1;
        check("t4_stall_push_ready", 32'(push_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_pop($sformatf("t4_stall%0d", i), 0);
            check($sformatf("t4_stall%0d_push_ready", i), 32'(push_ready), 32'd0);
        end
        pop_ready = 1'b1;
        #1;
        check("t4_release_push_ready", 32'(push_ready), 32'b001);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_pop($sformatf("t4_resume%0d", i), seq4[i]);
        end

        // Flow 0 valid for one cycle only; flow 1 then owns every cycle.
        cfg_weight = {4'd0, 4'd3, 4'd3};
        push_valid = 3'b011;
        do_reset();
        tick();
        push_valid = 3'b010;
        expect_pop("t5_pop0", 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_pop($sformatf("t5_f1_%0d", i), 1);
        end

        // Weights {4,4}; flow 0 weight drops to 1 after its second grant.
        cfg_weight = {4'd0, 4'd4, 4'd4};
        push_valid = 3'b011;
        do_reset();
        tick();
        expect_pop("t6_pop0", 0);
        tick();
        expect_pop("t6_pop1", 0);
        cfg_weight[0] = 4'd1;
        #1;
        check("t6_yield_push_ready", 32'(push_ready), 32'b010);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_pop($sformatf("t6_%0d", i), seq6[i]);
        end

        push_valid = 3'b000;
        tick();
        tick();
        check("idle_pop_valid", 32'(pop_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
